// File: rtl/fmap_window_reader.sv
// Consumer-side reader for pool_memo banks: passes producer controls through while idle,
// then walks every KxK window, streaming two elements per cycle from all banks.
module fmap_window_reader #(
   parameter int DATA_WIDTH      = 16,
   parameter int NUM_MULT        = 4,
   parameter int POOL_ADDR_WIDTH = 10,
   parameter int MAP_W           = 24,
   parameter int MAP_H           = 24,
   parameter int K               = 5,
   parameter int S               = 1,
   parameter int READ_LATENCY    = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [POOL_ADDR_WIDTH-1:0]     wr_address_a,
   input  logic [POOL_ADDR_WIDTH-1:0]     wr_address_b,
   input  logic                           wr_rden_a,
   input  logic                           wr_rden_b,
   input  logic                           wr_wren_a,
   input  logic                           wr_wren_b,
   output logic [POOL_ADDR_WIDTH-1:0]     address_a_t_use_out,
   output logic [POOL_ADDR_WIDTH-1:0]     address_b_t_use_out,
   output logic                           rden_a_use_out,
   output logic                           rden_b_use_out,
   output logic                           wren_a_use_out,
   output logic                           wren_b_use_out,
   input  logic [DATA_WIDTH*NUM_MULT-1:0] q_a_all,
   input  logic [DATA_WIDTH*NUM_MULT-1:0] q_b_all,
   output logic [DATA_WIDTH*NUM_MULT-1:0] feat_a_all,
   output logic [DATA_WIDTH*NUM_MULT-1:0] feat_b_all,
   output logic                           feat_valid,
   output logic                           window_last,
   output logic                           busy,
   output logic                           done
);
   localparam int OW    = (MAP_W - K) / S + 1;
   localparam int OH    = (MAP_H - K) / S + 1;
   localparam int PAIRS = (K * K + 1) / 2;
   localparam bit ODD   = ((K * K) % 2) == 1;
   localparam int AW    = POOL_ADDR_WIDTH;
   localparam int NW    = DATA_WIDTH * NUM_MULT;
   localparam int RL    = READ_LATENCY;
   localparam int PCW   = $clog2(PAIRS + 1);
   localparam int OXW   = $clog2(OW + 1);
   localparam int OYW   = $clog2(OH + 1);
   localparam int KXW   = $clog2(K + 2);
   localparam int DCW   = $clog2(RL + 1);
   localparam logic [AW-1:0]  ROW_STEP   = AW'(MAP_W);
   localparam logic [AW-1:0]  COL_STRIDE = AW'(S);
   localparam logic [AW-1:0]  ROW_STRIDE = AW'(S * MAP_W);
   localparam logic [KXW-1:0] K_C        = KXW'(K);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t         state_q, state_d;
   logic [PCW-1:0] pair_q, pair_d;
   logic [OXW-1:0] ox_q, ox_d;
   logic [OYW-1:0] oy_q, oy_d;
   logic [KXW-1:0] kx_q, kx_d;
   logic [AW-1:0]  row_off_q, row_off_d;
   logic [AW-1:0]  win_base_q, win_base_d;
   logic [AW-1:0]  row_base_q, row_base_d;
   logic [AW-1:0]  addr_b_hold_q, addr_b_hold_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic [RL-1:0]  vld_sr_q, vld_sr_d, last_sr_q, last_sr_d, bz_sr_q, bz_sr_d;
   logic [NW-1:0]  feat_a_q, feat_a_d, feat_b_q, feat_b_d;
   logic           feat_valid_q, feat_valid_d, window_last_q, window_last_d, done_q, done_d;

   logic           last_pair, b_skip, b_wrap, issue;
   logic [KXW-1:0] kx_b, kx_a2;
   logic [AW-1:0]  addr_a, addr_b, addr_b_sel;

   // Port b reads the element after port a; it may fall onto the next window row.
   always_comb begin
      last_pair  = (pair_q == PCW'(PAIRS - 1));
      b_skip     = ODD && last_pair;
      kx_b       = kx_q + KXW'(1);
      kx_a2      = kx_q + KXW'(2);
      b_wrap     = (kx_b == K_C);
      addr_a     = win_base_q + row_off_q + AW'(kx_q);
      addr_b     = win_base_q + row_off_q + (b_wrap ? ROW_STEP : AW'(kx_b));
      addr_b_sel = b_skip ? addr_b_hold_q : addr_b;
   end

   always_comb begin
      state_d             = state_q;
      pair_d              = pair_q;
      ox_d                = ox_q;
      oy_d                = oy_q;
      kx_d                = kx_q;
      row_off_d           = row_off_q;
      win_base_d          = win_base_q;
      row_base_d          = row_base_q;
      addr_b_hold_d       = addr_b_hold_q;
      drain_d             = drain_q;
      issue               = 1'b0;
      busy                = 1'b0;
      address_a_t_use_out = wr_address_a;
      address_b_t_use_out = wr_address_b;
      rden_a_use_out      = wr_rden_a;
      rden_b_use_out      = wr_rden_b;
      wren_a_use_out      = wr_wren_a;
      wren_b_use_out      = wr_wren_b;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = READ;
               pair_d     = '0;
               ox_d       = '0;
               oy_d       = '0;
               kx_d       = '0;
               row_off_d  = '0;
               win_base_d = '0;
               row_base_d = '0;
            end
         end
         READ: begin
            busy                = 1'b1;
            issue               = 1'b1;
            address_a_t_use_out = addr_a;
            address_b_t_use_out = addr_b_sel;
            addr_b_hold_d       = addr_b_sel;
            rden_a_use_out      = 1'b1;
            rden_b_use_out      = !b_skip;
            wren_a_use_out      = 1'b0;
            wren_b_use_out      = 1'b0;
            if (last_pair) begin
               pair_d    = '0;
               kx_d      = '0;
               row_off_d = '0;
               if (ox_q == OXW'(OW - 1)) begin
                  ox_d = '0;
                  if (oy_q == OYW'(OH - 1)) begin
                     state_d = DRAIN;
                     drain_d = '0;
                  end else begin
                     oy_d       = oy_q + OYW'(1);
                     row_base_d = row_base_q + ROW_STRIDE;
                     win_base_d = row_base_q + ROW_STRIDE;
                  end
               end else begin
                  ox_d       = ox_q + OXW'(1);
                  win_base_d = win_base_q + COL_STRIDE;
               end
            end else begin
               pair_d = pair_q + PCW'(1);
               if (kx_a2 >= K_C) begin
                  kx_d      = kx_a2 - K_C;
                  row_off_d = row_off_q + ROW_STEP;
               end else begin
                  kx_d = kx_a2;
               end
            end
         end
         DRAIN: begin
            busy                = 1'b1;
            address_a_t_use_out = addr_a;
            address_b_t_use_out = addr_b_hold_q;
            rden_a_use_out      = 1'b0;
            rden_b_use_out      = 1'b0;
            wren_a_use_out      = 1'b0;
            wren_b_use_out      = 1'b0;
            drain_d             = drain_q + DCW'(1);
            if (drain_q == DCW'(RL - 1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Flags ride a delay line matching the memory latency, then the q register stage.
   always_comb begin
      vld_sr_d      = (vld_sr_q << 1) | RL'(issue);
      last_sr_d     = (last_sr_q << 1) | RL'(issue && last_pair);
      bz_sr_d       = (bz_sr_q << 1) | RL'(issue && b_skip);
      feat_a_d      = q_a_all;
      feat_b_d      = bz_sr_q[RL-1] ? '0 : q_b_all;
      feat_valid_d  = vld_sr_q[RL-1];
      window_last_d = vld_sr_q[RL-1] && last_sr_q[RL-1];
      done_d        = (state_q == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         pair_q        <= '0;
         ox_q          <= '0;
         oy_q          <= '0;
         kx_q          <= '0;
         row_off_q     <= '0;
         win_base_q    <= '0;
         row_base_q    <= '0;
         addr_b_hold_q <= '0;
         drain_q       <= '0;
         vld_sr_q      <= '0;
         last_sr_q     <= '0;
         bz_sr_q       <= '0;
         feat_a_q      <= '0;
         feat_b_q      <= '0;
         feat_valid_q  <= 1'b0;
         window_last_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pair_q        <= pair_d;
         ox_q          <= ox_d;
         oy_q          <= oy_d;
         kx_q          <= kx_d;
         row_off_q     <= row_off_d;
         win_base_q    <= win_base_d;
         row_base_q    <= row_base_d;
         addr_b_hold_q <= addr_b_hold_d;
         drain_q       <= drain_d;
         vld_sr_q      <= vld_sr_d;
         last_sr_q     <= last_sr_d;
         bz_sr_q       <= bz_sr_d;
         feat_a_q      <= feat_a_d;
         feat_b_q      <= feat_b_d;
         feat_valid_q  <= feat_valid_d;
         window_last_q <= window_last_d;
         done_q        <= done_d;
      end
   end

   assign feat_a_all  = feat_a_q;
   assign feat_b_all  = feat_b_q;
   assign feat_valid  = feat_valid_q;
   assign window_last = window_last_q;
   assign done        = done_q;
endmodule

// File: tb/tb_fmap_window_reader.sv
// Directed bench for fmap_window_reader on a 4x4 map, 3x3 window, stride 1,
// with a two-cycle memory model returning address + bank*1000.
module tb_fmap_window_reader;
   localparam int DW = 16;
   localparam int NM = 4;
   localparam int AW = 10;

   logic          clock = 1'b0;
   logic          reset, start;
   logic [AW-1:0] wr_address_a, wr_address_b;
   logic          wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b;
   logic [AW-1:0] address_a_t_use_out, address_b_t_use_out;
   logic          rden_a_use_out, rden_b_use_out, wren_a_use_out, wren_b_use_out;
   logic [DW*NM-1:0] q_a_all, q_b_all, feat_a_all, feat_b_all;
   logic          feat_valid, window_last, busy, done;

   fmap_window_reader #(
      .DATA_WIDTH(DW), .NUM_MULT(NM), .POOL_ADDR_WIDTH(AW),
      .MAP_W(4), .MAP_H(4), .K(3), .S(1), .READ_LATENCY(2)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .wr_address_a(wr_address_a), .wr_address_b(wr_address_b),
      .wr_rden_a(wr_rden_a), .wr_rden_b(wr_rden_b),
      .wr_wren_a(wr_wren_a), .wr_wren_b(wr_wren_b),
      .address_a_t_use_out(address_a_t_use_out), .address_b_t_use_out(address_b_t_use_out),
      .rden_a_use_out(rden_a_use_out), .rden_b_use_out(rden_b_use_out),
      .wren_a_use_out(wren_a_use_out), .wren_b_use_out(wren_b_use_out),
      .q_a_all(q_a_all), .q_b_all(q_b_all),
      .feat_a_all(feat_a_all), .feat_b_all(feat_b_all),
      .feat_valid(feat_valid), .window_last(window_last),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   logic [AW-1:0] pa, pb;
   always @(posedge clock) begin
      pa <= address_a_t_use_out;
      pb <= address_b_t_use_out;
      for (int i = 0; i < NM; i++) begin
         q_a_all[i*DW +: DW] <= DW'(i * 1000) + DW'(pa);
         q_b_all[i*DW +: DW] <= DW'(i * 1000) + DW'(pb);
      end
   end

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, first_rden = -1, n_done = 0, done_cyc = -1, wren_bad = 0;
   int qa0[$], qa2[$], qb0[$], qlast[$], qcyc[$], qrb[$];

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (busy && rden_a_use_out) begin
         if (first_rden < 0) first_rden = cyc;
         qrb.push_back(int'(rden_b_use_out));
      end
      if (busy && (wren_a_use_out || wren_b_use_out)) wren_bad++;
      if (feat_valid) begin
         qa0.push_back(int'(feat_a_all[0 +: DW]));
         qa2.push_back(int'(feat_a_all[2*DW +: DW]));
         qb0.push_back(int'(feat_b_all[0 +: DW]));
         qlast.push_back(int'(window_last));
         qcyc.push_back(cyc);
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      qa0.delete(); qa2.delete(); qb0.delete(); qlast.delete(); qcyc.delete(); qrb.delete();
      first_rden = -1; n_done = 0; done_cyc = -1; wren_bad = 0;
   endtask

   task automatic pulse_start();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300 && n_done == 0; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      check_val({tag, "_done_seen"}, n_done, 1);
   endtask

   int exp_a[5] = '{0, 2, 5, 8, 10};
   int exp_b[5] = '{1, 4, 6, 9, 0};
   int w_off[4] = '{0, 1, 4, 5};

   task automatic check_stream(input string tag);
      check_val({tag, "_valid_count"}, qa0.size(), 20);
      if (qa0.size() == 20) begin
         for (int w = 0; w < 4; w++)
            for (int j = 0; j < 5; j++) begin
               check_val($sformatf("%s_a_w%0d_p%0d", tag, w, j), qa0[w*5+j], exp_a[j] + w_off[w]);
               check_val($sformatf("%s_b_w%0d_p%0d", tag, w, j), qb0[w*5+j],
                         (j == 4) ? 0 : exp_b[j] + w_off[w]);
               check_val($sformatf("%s_last_w%0d_p%0d", tag, w, j), qlast[w*5+j], (j == 4) ? 1 : 0);
            end
         check_val({tag, "_gapless"}, qcyc[19] - qcyc[0], 19);
         check_val({tag, "_done_after_last"}, done_cyc, qcyc[19] + 1);
      end
   endtask

   int snap;

   initial begin
      reset = 1'b1; start = 1'b0;
      wr_address_a = '0; wr_address_b = '0;
      wr_rden_a = 1'b0; wr_rden_b = 1'b0; wr_wren_a = 1'b0; wr_wren_b = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_valid", int'(feat_valid), 0);
      check_val("rst_done", int'(done), 0);
      check_val("rst_last", int'(window_last), 0);
      check_val("rst_feat_a", int'(feat_a_all[0 +: DW]), 0);
      reset = 1'b0;

      @(posedge clock); #1;
      wr_address_a = 10'h155; wr_wren_a = 1'b1; wr_address_b = 10'h0AA; wr_rden_b = 1'b1;
      #1;
      check_val("pass_addr_a", int'(address_a_t_use_out), 'h155);
      check_val("pass_wren_a", int'(wren_a_use_out), 1);
      check_val("pass_addr_b", int'(address_b_t_use_out), 'h0AA);
      check_val("pass_rden_b", int'(rden_b_use_out), 1);

      // Normal run with a spurious start mid-READ and producer wren held high.
      clear_log();
      pulse_start();
      repeat (3) @(posedge clock);
      #1 check_val("run1_busy_read", int'(busy), 1);
      start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      wait_done("run1");
      check_stream("run1");
      check_val("run1_latency", (qcyc.size() > 0) ? qcyc[0] - first_rden : -1, 3);
      check_val("run1_bank2_first", (qa2.size() > 0) ? qa2[0] : -1, 2000);
      check_val("run1_bank2_w3p2", (qa2.size() > 17) ? qa2[17] : -1, 2000 + 5 + 5);
      check_val("run1_rden_b_p3", (qrb.size() > 3) ? qrb[3] : -1, 1);
      check_val("run1_rden_b_p4", (qrb.size() > 4) ? qrb[4] : -1, 0);
      check_val("run1_rden_issues", qrb.size(), 20);
      check_val("run1_no_wren", wren_bad, 0);
      check_val("run1_idle_pass", int'(address_a_t_use_out), 'h155);
      check_val("run1_idle_busy", int'(busy), 0);

      // Reset while window 2 is being delivered.
      clear_log();
      pulse_start();
      for (int i = 0; i < 200 && qa0.size() < 9; i++) @(posedge clock);
      check_val("rst_mid_reached", int'(qa0.size() >= 9), 1);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1;
      check_val("rst_mid_busy", int'(busy), 0);
      check_val("rst_mid_valid", int'(feat_valid), 0);
      check_val("rst_mid_pass", int'(address_a_t_use_out), 'h155);
      reset = 1'b0;
      snap = qa0.size();
      repeat (20) @(posedge clock);
      check_val("rst_mid_no_more_valid", qa0.size(), snap);
      check_val("rst_mid_no_done", n_done, 0);

      // Replay from address 0 after the aborted run.
      clear_log();
      pulse_start();
      wait_done("run2");
      check_stream("run2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
